// File: rtl/flash_packet_reader_if.sv
// Byte-link input and packet-stream output of the flash packet reader.
// master: the reader (consumes bytes, drives packets); slave: link source and packet sink.
interface flash_packet_reader_if;
   logic [7:0] datastream;
   logic       flashin;
   logic [7:0] pkt_data;
   logic       pkt_valid;
   logic       pkt_ready;
   logic       pkt_last;
   logic [3:0] pkt_len;

   modport master (
      input  datastream, flashin, pkt_ready,
      output pkt_data, pkt_valid, pkt_last, pkt_len
   );

   modport slave (
      output datastream, flashin, pkt_ready,
      input  pkt_data, pkt_valid, pkt_last, pkt_len
   );
endinterface

// File: rtl/flash_packet_reader.sv
// Reassembles SOF/LEN/payload/XOR-checksum frames from the flash byte link into whole packets.
// Optional FLASH_READER_STATS_EN adds saturating good_cnt/bad_cnt frame counters.
//
// state     | meaning
// S_IDLE    | hunting for SOF, other bytes ignored
// S_LEN     | SOF seen, next byte is payload length
// S_PAYLOAD | storing payload bytes, accumulating checksum
// S_CSUM    | next byte is compared against accumulated checksum
// S_DRAIN   | packet presented on the valid/ready stream
module flash_packet_reader #(
   parameter int         MAX_LEN = 8,
   parameter logic [7:0] SOF     = 8'hA5,
   parameter int         TIMEOUT = 64
) (
   input  logic                  clk,
   input  logic                  reset,
   flash_packet_reader_if.master link,
   output logic                  csum_err,
   output logic                  len_err,
   output logic                  timeout_err,
   output logic                  overrun
`ifdef FLASH_READER_STATS_EN
   ,
   output logic [7:0]            good_cnt,
   output logic [7:0]            bad_cnt
`endif
);

   localparam int PW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LEN     = 3'd1,
      S_PAYLOAD = 3'd2,
      S_CSUM    = 3'd3,
      S_DRAIN   = 3'd4
   } state_t;

   state_t          state_q, state_d;
   logic [3:0]      len_q, len_d;
   logic [7:0]      csum_q, csum_d;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]   rd_nxt;
   logic [TW-1:0]   tmo_q, tmo_d;
   logic [7:0]      data_q, data_d;
   logic            valid_q, valid_d;
   logic            last_q, last_d;
   logic            csum_err_q, csum_err_d;
   logic            len_err_q, len_err_d;
   logic            tmo_err_q, tmo_err_d;
   logic            overrun_q, overrun_d;
   logic            mem_we;
   logic            rx_active;
   logic [7:0]      mem_q [MAX_LEN];

   assign rd_nxt    = rd_ptr_q + PW'(1);
   assign rx_active = (state_q == S_LEN) || (state_q == S_PAYLOAD) || (state_q == S_CSUM);

   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      csum_d     = csum_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      tmo_d      = '0;
      data_d     = data_q;
      valid_d    = valid_q;
      last_d     = last_q;
      csum_err_d = 1'b0;
      len_err_d  = 1'b0;
      tmo_err_d  = 1'b0;
      overrun_d  = 1'b0;
      mem_we     = 1'b0;

      // A strobe on the expiry cycle takes precedence over the timeout.
      if (rx_active && !link.flashin) begin
         if (tmo_q == TW'(TIMEOUT - 2)) begin
            state_d   = S_IDLE;
            tmo_err_d = 1'b1;
         end else begin
            tmo_d = tmo_q + TW'(1);
         end
      end

      case (state_q)
         S_IDLE: begin
            if (link.flashin && link.datastream == SOF) state_d = S_LEN;
         end
         S_LEN: begin
            if (link.flashin) begin
               csum_d = link.datastream;
               if (link.datastream != 8'd0 && link.datastream <= 8'(MAX_LEN)) begin
                  len_d    = link.datastream[3:0];
                  wr_ptr_d = '0;
                  state_d  = S_PAYLOAD;
               end else begin
                  len_err_d = 1'b1;
                  state_d   = S_IDLE;
               end
            end
         end
         S_PAYLOAD: begin
            if (link.flashin) begin
               mem_we   = 1'b1;
               csum_d   = csum_q ^ link.datastream;
               wr_ptr_d = wr_ptr_q + PW'(1);
               if (4'(wr_ptr_q) == len_q - 4'd1) state_d = S_CSUM;
            end
         end
         S_CSUM: begin
            if (link.flashin) begin
               if (link.datastream == csum_q) begin
                  state_d  = S_DRAIN;
                  valid_d  = 1'b1;
                  rd_ptr_d = '0;
                  data_d   = mem_q[0];
                  last_d   = (len_q == 4'd1);
               end else begin
                  csum_err_d = 1'b1;
                  state_d    = S_IDLE;
               end
            end
         end
         S_DRAIN: begin
            overrun_d = link.flashin;
            if (valid_q && link.pkt_ready) begin
               if (last_q) begin
                  valid_d = 1'b0;
                  last_d  = 1'b0;
                  data_d  = 8'h00;
                  state_d = S_IDLE;
               end else begin
                  rd_ptr_d = rd_nxt;
                  data_d   = mem_q[rd_nxt];
                  last_d   = (4'(rd_nxt) == len_q - 4'd1);
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         len_q      <= '0;
         csum_q     <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         tmo_q      <= '0;
         data_q     <= '0;
         valid_q    <= 1'b0;
         last_q     <= 1'b0;
         csum_err_q <= 1'b0;
         len_err_q  <= 1'b0;
         tmo_err_q  <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         csum_q     <= csum_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         tmo_q      <= tmo_d;
         data_q     <= data_d;
         valid_q    <= valid_d;
         last_q     <= last_d;
         csum_err_q <= csum_err_d;
         len_err_q  <= len_err_d;
         tmo_err_q  <= tmo_err_d;
         overrun_q  <= overrun_d;
      end
   end

   // Payload storage needs no reset: it is only read after a complete frame rewrites it.
   always_ff @(posedge clk) begin
      if (mem_we) mem_q[wr_ptr_q] <= link.datastream;
   end

   assign link.pkt_data  = data_q;
   assign link.pkt_valid = valid_q;
   assign link.pkt_last  = last_q;
   assign link.pkt_len   = len_q;
   assign csum_err       = csum_err_q;
   assign len_err        = len_err_q;
   assign timeout_err    = tmo_err_q;
   assign overrun        = overrun_q;

`ifdef FLASH_READER_STATS_EN
   logic [7:0] good_cnt_q, good_cnt_d;
   logic [7:0] bad_cnt_q, bad_cnt_d;

   always_comb begin
      good_cnt_d = good_cnt_q;
      bad_cnt_d  = bad_cnt_q;
      if (state_q == S_CSUM && state_d == S_DRAIN && good_cnt_q != 8'hFF)
         good_cnt_d = good_cnt_q + 8'd1;
      if ((csum_err_d || len_err_d || tmo_err_d) && bad_cnt_q != 8'hFF)
         bad_cnt_d = bad_cnt_q + 8'd1;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         good_cnt_q <= '0;
         bad_cnt_q  <= '0;
      end else begin
         good_cnt_q <= good_cnt_d;
         bad_cnt_q  <= bad_cnt_d;
      end
   end

   assign good_cnt = good_cnt_q;
   assign bad_cnt  = bad_cnt_q;
`endif

endmodule

// File: tb/tb_flash_packet_reader.sv
// Self-checking bench for flash_packet_reader: directed frame table, corner sequences,
// and random frames scored against a frame-level expectation list.
module tb_flash_packet_reader;
   localparam int TMO = 64;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   logic csum_err, len_err, timeout_err, overrun;
`ifdef FLASH_READER_STATS_EN
   logic [7:0] good_cnt, bad_cnt;
`endif

   flash_packet_reader_if ifc ();

   flash_packet_reader #(.MAX_LEN(8), .SOF(8'hA5), .TIMEOUT(TMO)) dut (
      .clk         (clk),
      .reset       (reset),
      .link        (ifc.master),
      .csum_err    (csum_err),
      .len_err     (len_err),
      .timeout_err (timeout_err),
      .overrun     (overrun)
`ifdef FLASH_READER_STATS_EN
      ,
      .good_cnt    (good_cnt),
      .bad_cnt     (bad_cnt)
`endif
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;
   bit mon_en  = 1'b0;
   bit rnd_rdy = 1'b0;
   int obs_q[$];
   int exp_q[$];

   typedef struct {
      logic [191:0] stim;
      int           nb;
      logic [2:0]   err;   // expected {csum_err, len_err, timeout_err}
      int           len;
      logic [119:0] dv;
   } vec_t;
   vec_t tbl[9];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic cyc();
      if (rnd_rdy) ifc.pkt_ready = ($urandom_range(0, 3) != 0);
      if (mon_en && ifc.pkt_valid && ifc.pkt_ready)
         obs_q.push_back((int'(ifc.pkt_len) << 12) | (int'(ifc.pkt_last) << 8) | int'(ifc.pkt_data));
      @(posedge clk);
      #1;
      if (mon_en) begin
         if (csum_err)    obs_q.push_back(32'h200);
         if (len_err)     obs_q.push_back(32'h300);
         if (timeout_err) obs_q.push_back(32'h400);
         if (overrun)     obs_q.push_back(32'h500);
      end
   endtask

   task automatic strobe(input logic [7:0] b);
      ifc.flashin    = 1'b1;
      ifc.datastream = b;
      cyc();
      ifc.flashin    = 1'b0;
      ifc.datastream = 8'h00;
   endtask

   task automatic send_vec(input logic [191:0] s, input int nb);
      for (int j = 0; j < nb; j++) strobe(s[8*(nb-1-j) +: 8]);
   endtask

   task automatic send_gap(input logic [7:0] b);
      repeat ($urandom_range(0, 3)) cyc();
      strobe(b);
   endtask

   task automatic drain_expect(input string nm, input int len, input logic [119:0] dv);
      for (int i = 0; i < len; i++) begin
         chk({nm, " valid"}, 32'(ifc.pkt_valid), 32'd1);
         chk({nm, " data"}, 32'(ifc.pkt_data), 32'(dv[8*(len-1-i) +: 8]));
         chk({nm, " last"}, 32'(ifc.pkt_last), 32'(i == len - 1));
         chk({nm, " len"}, 32'(ifc.pkt_len), 32'(len));
         cyc();
      end
      chk({nm, " valid after"}, 32'(ifc.pkt_valid), 32'd0);
   endtask

   task automatic chk_zero(input string nm);
      chk({nm, " flags"}, 32'({ifc.pkt_valid, ifc.pkt_last, csum_err, len_err, timeout_err, overrun}), 32'd0);
      chk({nm, " data"}, 32'(ifc.pkt_data), 32'd0);
      chk({nm, " len"}, 32'(ifc.pkt_len), 32'd0);
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic seen;
      ifc.flashin    = 1'b0;
      ifc.datastream = 8'h00;
      ifc.pkt_ready  = 1'b1;

      reset = 1'b0;
      cyc();
      cyc();
      chk_zero("reset");
      reset = 1'b1;

      tbl[0] = '{192'hA5_03_11_22_33_03, 6, 3'b000, 3, 120'h11_22_33};
      tbl[1] = '{192'hA5_03_11_22_33_04, 6, 3'b100, 0, 120'h0};
      tbl[2] = '{192'hA5_00, 2, 3'b010, 0, 120'h0};
      tbl[3] = '{192'hA5_09, 2, 3'b010, 0, 120'h0};
      tbl[4] = '{192'hA5_08_01_02_03_04_05_06_07_08_00, 11, 3'b000, 8, 120'h01_02_03_04_05_06_07_08};
      tbl[5] = '{192'hA5_01_A5_A4, 4, 3'b000, 1, 120'hA5};
      tbl[6] = '{192'h33_A5_02_7E_81_FD, 6, 3'b000, 2, 120'h7E_81};
      tbl[7] = '{192'hA5_0F, 2, 3'b010, 0, 120'h0};
      tbl[8] = '{192'hA5_02_A5_A5_02, 5, 3'b000, 2, 120'hA5_A5};

      for (int t = 0; t < 9; t++) begin
         send_vec(tbl[t].stim, tbl[t].nb);
         chk($sformatf("vec%0d err", t), 32'({csum_err, len_err, timeout_err}), 32'(tbl[t].err));
         if (tbl[t].err == 3'b000) begin
            drain_expect($sformatf("vec%0d", t), tbl[t].len, tbl[t].dv);
         end else begin
            chk($sformatf("vec%0d no valid", t), 32'(ifc.pkt_valid), 32'd0);
            cyc();
            chk($sformatf("vec%0d err one-shot", t), 32'({csum_err, len_err, timeout_err, ifc.pkt_valid}), 32'd0);
         end
      end

      // Strobe on the 63rd idle cycle is accepted.
      send_vec(192'hA5_02_7E, 3);
      seen = 1'b0;
      repeat (TMO - 2) begin cyc(); seen |= timeout_err; end
      chk("tmo none before 63", 32'(seen), 32'd0);
      strobe(8'h55);
      chk("tmo strobe on 63 wins", 32'(timeout_err), 32'd0);
      strobe(8'h29);
      drain_expect("tmo late byte", 2, 120'h7E_55);

      // 63 idle cycles abandon the frame.
      send_vec(192'hA5_02_7E, 3);
      seen = 1'b0;
      repeat (TMO - 2) begin cyc(); seen |= timeout_err; end
      chk("tmo early", 32'(seen), 32'd0);
      cyc();
      chk("tmo fires", 32'({csum_err, len_err, timeout_err, ifc.pkt_valid}), 32'b0010);
      cyc();
      chk("tmo one-shot", 32'(timeout_err), 32'd0);
      send_vec(192'hA5_01_A5_A4, 4);
      drain_expect("after tmo", 1, 120'hA5);

      // Back-pressure with an overrun byte during drain.
      ifc.pkt_ready = 1'b0;
      send_vec(192'hA5_02_C3_3C_FD, 5);
      cyc();
      cyc();
      strobe(8'hA5);
      chk("overrun pulse", 32'(overrun), 32'd1);
      cyc();
      chk("overrun one-shot", 32'(overrun), 32'd0);
      cyc();
      chk("stall hold", 32'({ifc.pkt_valid, ifc.pkt_last, ifc.pkt_data}), 32'h2C3);
      ifc.pkt_ready = 1'b1;
      drain_expect("stall drain", 2, 120'hC3_3C);

      // Reset mid-payload: trailing bytes must not complete a packet.
      send_vec(192'hA5_04_11_22, 4);
      reset = 1'b0;
      cyc();
      chk_zero("rst payload");
      reset = 1'b1;
      send_vec(192'h33_44_40, 3);
      cyc();
      chk("rst payload no pkt", 32'(ifc.pkt_valid), 32'd0);

      // Reset mid-drain.
      ifc.pkt_ready = 1'b0;
      send_vec(192'hA5_01_A5_A4, 4);
      chk("rst drain valid before", 32'(ifc.pkt_valid), 32'd1);
      reset = 1'b0;
      cyc();
      chk_zero("rst drain");
      reset = 1'b1;
      ifc.pkt_ready = 1'b1;
      cyc();
      chk("rst drain stays idle", 32'(ifc.pkt_valid), 32'd0);

`ifdef FLASH_READER_STATS_EN
      reset = 1'b0;
      cyc();
      reset = 1'b1;
      chk("stats reset", 32'({good_cnt, bad_cnt}), 32'd0);
      repeat (3) begin send_vec(192'hA5_01_A5_A4, 4); cyc(); end
      send_vec(192'hA5_00, 2);
      cyc();
      send_vec(192'hA5_03_11_22_33_04, 6);
      cyc();
      chk("stats good 3", 32'(good_cnt), 32'd3);
      chk("stats bad 2", 32'(bad_cnt), 32'd2);
      repeat (300) begin send_vec(192'hA5_01_A5_A4, 4); cyc(); end
      chk("stats good saturate", 32'(good_cnt), 32'hFF);
      chk("stats bad held", 32'(bad_cnt), 32'd2);
`endif

      // Random frames: expectation derived from frame rules only.
      mon_en  = 1'b1;
      rnd_rdy = 1'b1;
      for (int f = 0; f < 60; f++) begin
         logic [7:0] fr[$];
         logic [7:0] b;
         logic [7:0] cs;
         int kind, len, keep;
         fr.delete();
         repeat ($urandom_range(0, 2)) begin
            b = 8'($urandom_range(0, 255));
            if (b == 8'hA5) b = 8'h5A;
            send_gap(b);
         end
         kind = int'($urandom_range(0, 9));
         if (kind == 7)      len = 0;
         else if (kind == 8) len = int'($urandom_range(9, 255));
         else                len = int'($urandom_range(1, 8));
         fr.push_back(8'hA5);
         fr.push_back(8'(len));
         cs = 8'(len);
         if (kind <= 6 || kind == 9) begin
            for (int i = 0; i < len; i++) begin
               b = 8'($urandom_range(0, 255));
               fr.push_back(b);
               cs ^= b;
            end
         end
         if (kind <= 5) begin
            fr.push_back(cs);
            for (int i = 0; i < len; i++)
               exp_q.push_back((len << 12) | (int'(i == len - 1) << 8) | int'(fr[i+2]));
         end else if (kind == 6) begin
            fr.push_back(cs ^ 8'($urandom_range(1, 255)));
            exp_q.push_back(32'h200);
         end else if (kind == 7 || kind == 8) begin
            exp_q.push_back(32'h300);
         end else begin
            exp_q.push_back(32'h400);
         end
         if (kind == 9) begin
            keep = int'($urandom_range(1, len + 2));
            for (int k = 0; k < keep; k++) send_gap(fr[k]);
            repeat (TMO + 4) cyc();
         end else begin
            foreach (fr[k]) send_gap(fr[k]);
            cyc();
            for (int w = 0; w < 400 && ifc.pkt_valid; w++) cyc();
            chk($sformatf("rnd frame%0d drained", f), 32'(ifc.pkt_valid), 32'd0);
         end
      end
      repeat (4) cyc();
      mon_en  = 1'b0;
      rnd_rdy = 1'b0;

      chk("rnd event count", obs_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
         chk($sformatf("rnd event%0d", i), obs_q[i], exp_q[i]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
